// File: rtl/multicycle_datapath.sv
// Multi-cycle 16-bit-instruction core: IMEM, register file, DMEM and ALU sequenced by a
// fetch/decode/execute/memory/writeback FSM, with host program load and debug read port.
module multicycle_datapath #(
  parameter int DATA_W     = 16,
  parameter int REG_N      = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [15:0]                   imem_wdata,
  input  logic [2:0]                    dbg_raddr,
  output logic [DATA_W-1:0]             dbg_rdata,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    dbg_state
);

  localparam int PW = $clog2(IMEM_DEPTH);
  localparam int AW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  logic [15:0]       imem_q [IMEM_DEPTH];
  logic [DATA_W-1:0] rf_q   [8];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

  state_t            state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [DATA_W-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic              rf_we, dm_we;

  logic [3:0]        op;
  logic [2:0]        rd_f, rs_f, rt_f;
  logic [DATA_W-1:0] imm_ext, rs_val, rt_val, rd_val, rf_wdata;
  logic [PW-1:0]     pc_inc, br_tgt;
  logic [AW-1:0]     dm_addr;

  // r0 and any field beyond the implemented register count read as zero.
  function automatic logic [DATA_W-1:0] rf_read(input logic [2:0] idx);
    if (idx == 3'd0 || int'(idx) >= REG_N) return '0;
    return rf_q[idx];
  endfunction

  assign op       = ir_q[15:12];
  assign rd_f     = ir_q[11:9];
  assign rs_f     = ir_q[8:6];
  assign rt_f     = ir_q[5:3];
  assign imm_ext  = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
  assign rs_val   = rf_read(rs_f);
  assign rt_val   = rf_read(rt_f);
  assign rd_val   = rf_read(rd_f);
  assign pc_inc   = pc_q + PW'(1);
  assign br_tgt   = pc_inc + PW'(imm_ext);
  assign dm_addr  = AW'(alu_q);
  assign rf_wdata = (op == 4'h6) ? mdr_q : alu_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    rf_we   = 1'b0;
    dm_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_d    = imem_q[pc_q];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // SW stores rd and branches compare rd against rs, so B carries rd for those.
        a_d   = rs_val;
        b_d   = (op == 4'h7 || op == 4'h8 || op == 4'h9) ? rd_val : rt_val;
        imm_d = imm_ext;
        case (op)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: state_d = S_EXEC;
          4'h8: begin
            pc_d    = (rd_val == rs_val) ? br_tgt : pc_inc;
            state_d = S_FETCH;
          end
          4'h9: begin
            pc_d    = (rd_val != rs_val) ? br_tgt : pc_inc;
            state_d = S_FETCH;
          end
          4'hA: begin
            pc_d    = PW'(ir_q[11:0]);
            state_d = S_FETCH;
          end
          4'hF: state_d = S_HALT;
          default: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        case (op)
          4'h0:    alu_d = a_q + b_q;
          4'h1:    alu_d = a_q - b_q;
          4'h2:    alu_d = a_q & b_q;
          4'h3:    alu_d = a_q | b_q;
          4'h4:    alu_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
          default: alu_d = a_q + imm_q;
        endcase
        state_d = (op == 4'h6 || op == 4'h7) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (op == 4'h6) begin
          mdr_d   = dmem_q[dm_addr];
          state_d = S_WB;
        end else begin
          dm_we   = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (rf_we && rd_f != 3'd0 && int'(rd_f) < REG_N) rf_q[rd_f] <= rf_wdata;
      if (dm_we) dmem_q[dm_addr] <= b_q;
    end
  end

  // Program memory survives reset; only the host may write it, and only while idle.
  always_ff @(posedge clk) begin
    if (imem_we && state_q == S_IDLE) imem_q[imem_waddr] <= imem_wdata;
  end

  assign dbg_rdata = rf_read(dbg_raddr);
  assign pc        = pc_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign done      = (state_q == S_HALT);
  assign dbg_state = state_q;

endmodule
